// File: rtl/mulu_seq_shiftadd.sv
// Sequential unsigned shift-add multiplier (P = X * Y) with valid/ready on both sides.
// Optional macro MULU_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier bits are zero.
module mulu_seq_shiftadd #(
   parameter int unsigned X_WIDTH = 8,
   parameter int unsigned Y_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [X_WIDTH-1:0]           x,
   input  logic [Y_WIDTH-1:0]           y,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [X_WIDTH+Y_WIDTH-1:0]   p,
   output logic                         busy
);

   localparam int unsigned P_WIDTH = X_WIDTH + Y_WIDTH;
   localparam int unsigned CNT_W   = $clog2(Y_WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [X_WIDTH-1:0]   xr_q, xr_d;
   logic [Y_WIDTH-1:0]   yr_q, yr_d;
   logic [P_WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [P_WIDTH-1:0]   p_q, p_d;
   logic                 out_valid_q, out_valid_d;
   logic                 busy_q, busy_d;
   logic                 init_q;

   logic [P_WIDTH-1:0]   addend;
   logic [P_WIDTH-1:0]   sum;
   logic                 last_step;

   // Accept is held off for the first cycle after reset release.
   assign in_ready = init_q & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));

   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign p         = p_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         xr_q        <= '0;
         yr_q        <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         p_q         <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         init_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         xr_q        <= xr_d;
         yr_q        <= yr_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         p_q         <= p_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         init_q      <= 1'b1;
      end
   end

   // One partial product per RUN cycle; the add is P_WIDTH wide so it cannot overflow.
   always_comb begin
      addend = yr_q[0] ? (P_WIDTH'(xr_q) << cnt_q) : '0;
      sum    = acc_q + addend;
`ifdef MULU_EARLY_TERM_EN
      last_step = (cnt_q == CNT_W'(Y_WIDTH - 1)) | ((yr_q >> 1) == '0);
`else
      last_step = (cnt_q == CNT_W'(Y_WIDTH - 1));
`endif
   end

   always_comb begin
      state_d = state_q;
      xr_d    = xr_q;
      yr_d    = yr_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      p_d     = p_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               xr_d    = x;
               yr_d    = y;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d = sum;
            yr_d  = yr_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step) begin
               p_d     = sum;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // A result take may coincide with the next operand accept.
            if (out_ready) begin
               if (in_valid && in_ready) begin
                  xr_d    = x;
                  yr_d    = y;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = S_RUN;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d == S_RUN);
   end

endmodule
